// File: rtl/picomips_alu.sv
// picoMIPS execute stage: single-cycle ALU ops plus a sequential signed shift-add multiply.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate to the signed range, carry flags saturation.
module picomips_alu #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [ADDR_WIDTH-1:0] dst,
    output logic                  busy,
    output logic                  w,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [WIDTH-1:0]      wdata,
    output logic                  zero,
    output logic                  carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_e;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000, OP_SUB  = 3'b001, OP_AND  = 3'b010, OP_OR  = 3'b011,
        OP_PASS = 3'b100, OP_MULH = 3'b101, OP_MULL = 3'b110, OP_NOP = 3'b111
    } op_e;

    state_e                 state, state_next;
    op_e                    op_in, op_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic [2*WIDTH-1:0]     mcand, acc, acc_next;
    logic [WIDTH-1:0]       mplier, mul_res, sc_res;
    logic [CNT_W-1:0]       cnt;
    logic                   is_mul, last_iter, sc_write, sc_carry;
    logic [WIDTH:0]         sum_ext, diff_ext;

    assign op_in     = op_e'(op);
    assign is_mul    = (op_in == OP_MULH) || (op_in == OP_MULL);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = is_mul ? S_MUL : S_WB;
            S_MUL:   if (last_iter) state_next = S_WB;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_write = 1'b1;
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        case (op_in)
            OP_ADD: begin
                sc_res = sum_ext[WIDTH-1:0];
`ifdef ALU_SAT_EN
                if (a[WIDTH-1] == b[WIDTH-1] && sum_ext[WIDTH-1] != a[WIDTH-1]) begin
                    sc_res   = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    sc_carry = 1'b1;
                end
`else
                sc_carry = sum_ext[WIDTH];
`endif
            end
            OP_SUB: begin
                sc_res = diff_ext[WIDTH-1:0];
`ifdef ALU_SAT_EN
                if (a[WIDTH-1] != b[WIDTH-1] && diff_ext[WIDTH-1] != a[WIDTH-1]) begin
                    sc_res   = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    sc_carry = 1'b1;
                end
`else
                sc_carry = diff_ext[WIDTH];
`endif
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_PASS: sc_res = b;
            default: sc_write = 1'b0;
        endcase
    end

    // Multiplier MSB carries weight -2^(WIDTH-1), so the final partial product is subtracted.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) acc_next = last_iter ? acc - mcand : acc + mcand;
        mul_res = (op_q == OP_MULH) ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w      <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            op_q   <= OP_ADD;
            dst_q  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            w <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_q   <= op_in;
                    dst_q  <= dst;
                    mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                    if (!is_mul && sc_write) begin
                        w     <= 1'b1;
                        waddr <= dst;
                        wdata <= sc_res;
                        zero  <= (sc_res == '0);
                        carry <= sc_carry;
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        w     <= 1'b1;
                        waddr <= dst_q;
                        wdata <= mul_res;
                        zero  <= (mul_res == '0);
                        carry <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
